// File: rtl/arb_rr4.sv
// rtl/arb_rr4.sv - four-requester round-robin arbiter with bounded grant hold time
module arb_rr4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [1:0] idx_nxt;
    logic [1:0] winner;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic       timeout_nxt;
    logic       released;
    logic       expire;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    // hold_cnt counts completed grant cycles before the current one.
    assign released = !req[gnt_idx];
    assign expire   = (hold_cnt >= HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 4'b0000) state_nxt = GRANT;
            GRANT:   if (released || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_nxt     = gnt_idx;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    idx_nxt  = winner;
                    hold_nxt = 8'd0;
                end
            end
            GRANT: begin
                if (released) begin
                    ptr_nxt = gnt_idx + 2'd1;
                end else if (expire) begin
                    ptr_nxt     = gnt_idx + 2'd1;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx  <= 2'b00;
            ptr      <= 2'b00;
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            gnt_idx  <= idx_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign busy = (state == GRANT);
    assign gnt  = busy ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: tb/tb_arb_rr4.sv
// tb/tb_arb_rr4.sv - self-checking bench for arb_rr4 with MAX_HOLD=4
module tb_arb_rr4;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference: owner is the granted client or -1; held counts gnt-high cycles shown so far.
    int m_owner = -1;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_to    = 0;

    arb_rr4 #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                    end
                    m_idx  = m_owner;
                    m_held = 1;
                end
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (m_held == HOLD) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_to    = 1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",     32'(gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
            check("busy",    32'(busy),    32'(m_owner >= 0));
            check("timeout", 32'(timeout), 32'(m_to));
            check("onehot",  32'($countones(gnt) <= 1), 32'd1);
        end
    end

    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r_cur;
        int gc[4];
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;
        logic prev_busy;

        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_idx", 32'(gnt_idx), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        chk_en = 1'b1;

        // single request from client 2
        step(4'b0100, 1'b0);
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_idx", 32'(gnt_idx), 32'd2);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        check("single_release", 32'(gnt), 32'd0);
        check("model_ptr_after_single", 32'(m_ptr), 32'd3);
        step(4'b0000, 1'b0);

        // everyone requesting, each client drops after two grant cycles
        step(4'b0000, 1'b1);
        r_cur = 4'b1111;
        gc = '{0, 0, 0, 0};
        prev_busy = 1'b0;
        n = 0;
        while (order.size() < 5 && n < 60) begin
            step(r_cur, 1'b0);
            n++;
            if (busy) begin
                if (!prev_busy) order.push_back(int'(gnt_idx));
                gc[gnt_idx]++;
                if (gc[gnt_idx] == 2) begin
                    r_cur[gnt_idx] = 1'b0;
                    gc[gnt_idx] = 0;
                end
            end else begin
                r_cur = 4'b1111;
            end
            prev_busy = busy;
        end
        check("rr_grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // pointer wraps from 3 to 0
        step(4'b1000, 1'b0);
        check("wrap_first", 32'(gnt_idx), 32'd3);
        step(4'b0000, 1'b0);
        step(4'b1001, 1'b0);
        check("wrap_winner", 32'(gnt_idx), 32'd0);
        check("wrap_gnt", 32'(gnt), 32'h1);
        step(4'b0000, 1'b0);

        // hold-time expiry, twice, then a fresh contest
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            step(4'b0010, 1'b0);
            check("to_grant_idx", 32'(gnt_idx), 32'd1);
            while (gnt == 4'b0010 && n < 20) begin
                n++;
                step(4'b0010, 1'b0);
            end
            check("to_hold_cycles", 32'(n), 32'(HOLD));
            check("to_pulse", 32'(timeout), 32'd1);
            check("to_gnt_low", 32'(gnt), 32'd0);
        end
        step(4'b0011, 1'b0);
        check("to_next_winner", 32'(gnt_idx), 32'd0);
        check("to_pulse_cleared", 32'(timeout), 32'd0);
        step(4'b0000, 1'b0);

        // no preemption while client 2 holds
        step(4'b0100, 1'b0);
        check("nopre_grant", 32'(gnt), 32'h4);
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        check("nopre_hold", 32'(gnt), 32'h4);
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b0);
        check("nopre_next", 32'(gnt_idx), 32'd3);
        step(4'b0000, 1'b0);

        // release on the same edge the hold would expire: no pulse
        step(4'b0001, 1'b0);
        check("tie_grant", 32'(gnt), 32'h1);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("tie_no_timeout", 32'(timeout), 32'd0);
        check("tie_gnt_low", 32'(gnt), 32'd0);

        // reset in the middle of a grant
        step(4'b1000, 1'b0);
        check("rstmid_grant", 32'(gnt), 32'h8);
        step(4'b1000, 1'b1);
        check("rstmid_gnt", 32'(gnt), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_idx", 32'(gnt_idx), 32'd0);
        check("rstmid_timeout", 32'(timeout), 32'd0);
        step(4'b1010, 1'b0);
        check("rstmid_winner", 32'(gnt_idx), 32'd1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
